ifu_fetch_ctrl: RTL and testbench

IFU_FETCH_CTRL -- requirements
Module: ifu_fetch_ctrl

---
 rtl/ifu_pkg.sv | 18 +
 rtl/ifu_fetch_buf.sv | 66 ++++++
 rtl/ifu_fetch_ctrl.sv | 117 +++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
// Holds the reset PC, controller states and the fetch buffer entry.
package ifu_pkg;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fetch_buf.sv
// Circular fetch buffer: push at tail, pop at head, flush empties it.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fetch_buf
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  ifu_entry_t wdata_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output ifu_entry_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  ifu_entry_t    mem_q [DEPTH];

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
      unique case ({push_i, pop_i})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: head_o is masked while empty.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch controller: sequential PC, fault detection, redirect, buffer.
// Optional stall counter enabled by macro IFU_FETCH_PERF_EN.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter int          IM_WORDS  = 4096,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic [31:0] perf_stall_cycles
);

  // 33-bit bound so a window ending at 2^32 still compares correctly.
  localparam logic [32:0] IM_HI =
    {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        push, pop, full, empty, bad_pc;
  ifu_entry_t  wentry, head;

  assign rom_addr = pc_q;

  assign bad_pc = (pc_q[1:0] != 2'b00)
               || (pc_q < RESET_PC)
               || ({1'b0, pc_q} >= IM_HI);

  assign instr_valid = !empty;
  assign pop         = instr_valid && instr_ready;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign instr_fault = head.fault;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    wentry  = '0;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (!full || pop) begin
            push      = 1'b1;
            wentry.pc = pc_q;
            if (bad_pc) begin
              wentry.fault = 1'b1;
              state_d      = ST_FAULT;
            end else begin
              wentry.instr = rom_data;
              pc_d         = pc_q + 32'd4;
            end
          end
        end
        ST_FAULT: ;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifu_fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (wentry),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

`ifdef IFU_FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (instr_valid && !instr_ready && (perf_q != 32'hFFFF_FFFF))
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          IMW    = 4096;
  localparam int          DEPTH  = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr, rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        instr_fault;
  logic [31:0] perf_stall_cycles;

  int n_err = 0;
  int n_chk = 0;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_halt;
  logic [31:0] m_perf;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  assign rom_data = rom_word(rom_addr);

  ifu_fetch_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rom_addr          (rom_addr),
    .rom_data          (rom_data),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr             (instr),
    .instr_pc          (instr_pc),
    .instr_fault       (instr_fault),
    .perf_stall_cycles (perf_stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bad_pc(input logic [31:0] a);
    longint unsigned lo = RST_PC;
    longint unsigned hi = lo + 4 * IMW;
    longint unsigned x  = a;
    return (a % 4 != 0) || (x < lo) || (x >= hi);
  endfunction

  function automatic logic [31:0] exp_perf();
`ifdef IFU_FETCH_PERF_EN
    return m_perf;
`else
    return 32'h0;
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pc   = RST_PC;
    m_halt = 0;
    m_perf = 0;
  endfunction

  function automatic void model_update(input logic rv,
                                       input logic [31:0] rpc,
                                       input logic rdy);
    int   sz  = mq.size();
    bit   pop = (sz != 0) && rdy;
    ent_t e;
    if (sz != 0 && !rdy && m_perf != 32'hFFFF_FFFF) m_perf++;
    if (rv) begin
      mq.delete();
      m_pc   = rpc;
      m_halt = 0;
      return;
    end
    if (pop) void'(mq.pop_front());
    if (!m_halt && (sz < DEPTH || pop)) begin
      e.pc = m_pc;
      if (bad_pc(m_pc)) begin
        e.instr = 32'h0;
        e.fault = 1'b1;
        m_halt  = 1;
      end else begin
        e.instr = rom_word(m_pc);
        e.fault = 1'b0;
        m_pc    = m_pc + 32'd4;
      end
      mq.push_back(e);
    end
  endfunction

  task automatic compare_outputs();
    ent_t h = '0;
    if (mq.size() != 0) h = mq[0];
    check("valid", {31'b0, instr_valid}, {31'b0, mq.size() != 0});
    check("instr", instr, h.instr);
    check("pc", instr_pc, h.pc);
    check("fault", {31'b0, instr_fault}, {31'b0, h.fault});
    check("perf", perf_stall_cycles, exp_perf());
    if (!m_halt) check("rom_addr", rom_addr, m_pc);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic rv, input logic [31:0] rpc,
                      input logic rdy);
    compare_outputs();
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = rdy;
    #1;
    model_update(rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    #1;
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_perf", perf_stall_cycles, 32'h0);
    check("rst_addr", rom_addr, RST_PC);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_target();
    unique case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return RST_PC + 4 * $urandom_range(0, 40);
      6:       return 32'h0000_6FE0 + 4 * $urandom_range(0, 8);
      7:       return (RST_PC + $urandom_range(0, 63)) | 32'h1;
      8:       return 32'hFFFF_FFF8 + 4 * $urandom_range(0, 1);
      default: return 32'h0000_2FFC;
    endcase
  endfunction

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    model_reset();
    @(posedge clk);
    do_reset();

    // Streaming with constant ready
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("seq_pc", instr_pc, RST_PC + 4 * i);
      check("seq_instr", instr, rom_word(RST_PC + 4 * i));
      step(0, 0, 1);
    end

    // Backpressure fills buffer and holds fetch
    do_reset();
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    check("bp_addr", rom_addr, 32'h0000_3008);
    check("bp_head", instr_pc, 32'h0000_3000);
`ifdef IFU_FETCH_PERF_EN
    check("bp_perf", perf_stall_cycles, 32'd5);
`else
    check("bp_perf", perf_stall_cycles, 32'd0);
`endif

    // Redirect while full
    step(1, 32'h0000_3100, 0);
    check("rd_flush", {31'b0, instr_valid}, 32'h0);
    step(0, 0, 1);
    check("rd_pc", instr_pc, 32'h0000_3100);

    // Misaligned target faults once then halts
    step(1, 32'h0000_3002, 1);
    step(0, 0, 1);
    check("mis_fault", {31'b0, instr_fault}, 32'h1);
    check("mis_pc", instr_pc, 32'h0000_3002);
    check("mis_instr", instr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1);
      check("mis_halt", {31'b0, instr_valid}, 32'h0);
    end
    step(1, 32'h0000_3000, 1);
    step(0, 0, 1);
    check("mis_resume", instr_pc, 32'h0000_3000);

    // Upper bound of instruction memory
    step(1, 32'h0000_6FF0, 1);
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("top_pc", instr_pc, 32'h0000_6FF0 + 4 * i);
      check("top_fault", {31'b0, instr_fault}, {31'b0, i == 4});
      step(0, 0, 1);
    end
    check("top_halt", {31'b0, instr_valid}, 32'h0);

    // Reset mid-stream with full buffer
    step(1, 32'h0000_3000, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("mid_full", instr_pc, 32'h0000_3000);
    do_reset();
    step(0, 0, 1);
    check("mid_restart", instr_pc, 32'h0000_3000);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic rv;
      rv = ($urandom_range(0, 11) == 0) ||
           (m_halt && $urandom_range(0, 3) == 0);
      step(rv, rv ? pick_target() : 32'h0,
           $urandom_range(0, 9) < 7);
    end
    compare_outputs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
